trap_controller: RTL and testbench

- Sequences all machine-mode control-flow events for the RV32I core:
  - synchronous exceptions: ECALL, EBREAK, illegal instruction
  - timer and external interrupts
  - MRET
  - WFI
- Sits between the decode/control stage and the PC/CSR logic.
  - Kills the side effects of the faulting instruction.
  - Stalls fetch while the trap is handled.
  - Drives the CSR trap-entry and trap-return updates.
  - Supplies the redirected PC: mtvec, the vectored target, or mepc.

---
 rtl/trap_controller_if.sv | 42 ++++
 rtl/trap_controller.sv | 167 ++++++++++++++++
 tb/tb_trap_controller.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// Bundles the decode/CSR-facing signals of the machine-mode trap controller.
// The master side is the core pipeline and the slave side is the trap controller.
interface trap_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic [XLEN-1:0] pc;
    logic            exc_request;
    logic            inst_invalid;
    logic [XLEN-1:0] exc_cause;
    logic            exc_ret;
    logic            is_wfi;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc_in;
    logic            mstatus_mie;
    logic            mie_mtie;
    logic            mie_meie;
    logic            irq_timer;
    logic            irq_ext;
    logic            kill;
    logic            stall;
    logic            csr_trap_we;
    logic            csr_mret;
    logic [XLEN-1:0] epc_out;
    logic [XLEN-1:0] cause_out;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output instr_valid, pc, exc_request, inst_invalid, exc_cause, exc_ret, is_wfi,
               mtvec, mepc_in, mstatus_mie, mie_mtie, mie_meie, irq_timer, irq_ext,
        input  kill, stall, csr_trap_we, csr_mret, epc_out, cause_out,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  instr_valid, pc, exc_request, inst_invalid, exc_cause, exc_ret, is_wfi,
               mtvec, mepc_in, mstatus_mie, mie_mtie, mie_meie, irq_timer, irq_ext,
        output kill, stall, csr_trap_we, csr_mret, epc_out, cause_out,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: exceptions, interrupts, MRET and WFI for an RV32I core.
// kill/stall are decided in the detection cycle; CSR pulses and redirects come from registers.
module trap_controller #(
    parameter int XLEN           = 32,
    parameter int EXC_ILLEGAL    = 2,
    parameter int IRQ_TIMER_CODE = 7,
    parameter int IRQ_EXT_CODE   = 11
) (
    input  logic    clk,
    input  logic    rst,
    trap_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRAP_SAVE = 3'd1,
        S_TRAP_JUMP = 3'd2,
        S_RET_JUMP  = 3'd3,
        S_WFI_WAIT  = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_csr_trap_we;
    logic            r_csr_mret;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic            r_wfi_done;

    logic            w_wake;
    logic            w_irq_int;
    logic            w_trap_req;
    logic [XLEN-1:0] w_trap_cause;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_trap_target;
    logic            w_kill;
    logic            w_stall;

    assign w_wake     = (bus.irq_ext & bus.mie_meie) | (bus.irq_timer & bus.mie_mtie);
    assign w_irq_int  = bus.mstatus_mie & w_wake;
    assign w_trap_req = w_irq_int | bus.inst_invalid | bus.exc_request;
    assign w_trap_base = {bus.mtvec[XLEN-1:2], 2'b00};

    // Cause selection for a trap detected this cycle, by priority
    always_comb begin
        w_trap_cause = '0;
        if (w_irq_int) begin
            if (bus.irq_ext & bus.mie_meie) begin
                w_trap_cause = {1'b1, (XLEN-1)'(IRQ_EXT_CODE)};
            end else begin
                w_trap_cause = {1'b1, (XLEN-1)'(IRQ_TIMER_CODE)};
            end
        end else if (bus.inst_invalid) begin
            w_trap_cause = XLEN'(EXC_ILLEGAL);
        end else begin
            w_trap_cause = bus.exc_cause;
        end
    end

    // Vectored mode only offsets interrupts; the shift drops cause bits beyond XLEN
    always_comb begin
        w_trap_target = w_trap_base;
        if (bus.mtvec[1:0] == 2'b01 && r_cause[XLEN-1]) begin
            w_trap_target = w_trap_base + {r_cause[XLEN-3:0], 2'b00};
        end else begin
            w_trap_target = w_trap_base;
        end
    end

    // Same-cycle kill/stall; held low while reset is asserted
    always_comb begin
        w_kill  = 1'b0;
        w_stall = 1'b0;
        if (rst) begin
            w_kill  = 1'b0;
            w_stall = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.instr_valid) begin
                        w_stall = 1'b0;
                    end else if (w_trap_req) begin
                        w_kill  = 1'b1;
                        w_stall = 1'b1;
                    end else if (bus.exc_ret) begin
                        w_stall = 1'b1;
                    end else if (bus.is_wfi && !r_wfi_done) begin
                        w_stall = 1'b1;
                    end else begin
                        w_stall = 1'b0;
                    end
                end
                S_TRAP_SAVE: w_stall = 1'b1;
                S_WFI_WAIT:  w_stall = ~w_wake;
                default:     w_stall = 1'b0;
            endcase
        end
    end

    // FSM with registered CSR pulses, redirect and latched epc/cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_csr_trap_we    <= 1'b0;
            r_csr_mret       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_epc            <= '0;
            r_cause          <= '0;
            r_wfi_done       <= 1'b0;
        end else begin
            r_csr_trap_we    <= 1'b0;
            r_csr_mret       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_wfi_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.instr_valid) begin
                        r_state <= S_IDLE;
                    end else if (w_trap_req) begin
                        r_epc         <= bus.pc;
                        r_cause       <= w_trap_cause;
                        r_csr_trap_we <= 1'b1;
                        r_state       <= S_TRAP_SAVE;
                    end else if (bus.exc_ret) begin
                        r_csr_mret       <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= bus.mepc_in;
                        r_state          <= S_RET_JUMP;
                    end else if (bus.is_wfi && !r_wfi_done) begin
                        r_state <= S_WFI_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TRAP_SAVE: begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= w_trap_target;
                    r_state          <= S_TRAP_JUMP;
                end
                S_TRAP_JUMP: r_state <= S_IDLE;
                S_RET_JUMP:  r_state <= S_IDLE;
                S_WFI_WAIT: begin
                    if (w_wake) begin
                        r_wfi_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_WFI_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.kill           = w_kill;
    assign bus.stall          = w_stall;
    assign bus.csr_trap_we    = r_csr_trap_we;
    assign bus.csr_mret       = r_csr_mret;
    assign bus.epc_out        = r_epc;
    assign bus.cause_out      = r_cause;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_trap_controller.sv
// Randomized scoreboard bench for trap_controller: the driver predicts CSR/redirect events
// from the architectural trap rules, and a negedge monitor pops and compares them.
module tb_trap_controller;

    logic clk;
    logic rst;

    trap_if #(.XLEN(32)) bus ();

    trap_controller #(
        .XLEN(32), .EXC_ILLEGAL(2), .IRQ_TIMER_CODE(7), .IRQ_EXT_CODE(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        exc_req;
        logic        inv;
        logic [31:0] exc_cause;
        logic        ret;
        logic        wfi;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        mie;
        logic        mtie;
        logic        meie;
        logic        tim;
        logic        ext;
    } stim_t;

    typedef struct {
        logic        we;
        logic        mret;
        logic        redir;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.v = 1'b0; s.pc = 32'h0; s.exc_req = 1'b0; s.inv = 1'b0; s.exc_cause = 32'h0;
        s.ret = 1'b0; s.wfi = 1'b0; s.mtvec = 32'h0; s.mepc = 32'h0; s.mie = 1'b0;
        s.mtie = 1'b0; s.meie = 1'b0; s.tim = 1'b0; s.ext = 1'b0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.instr_valid  = s.v;
        bus.pc           = s.pc;
        bus.exc_request  = s.exc_req;
        bus.inst_invalid = s.inv;
        bus.exc_cause    = s.exc_cause;
        bus.exc_ret      = s.ret;
        bus.is_wfi       = s.wfi;
        bus.mtvec        = s.mtvec;
        bus.mepc_in      = s.mepc;
        bus.mstatus_mie  = s.mie;
        bus.mie_mtie     = s.mtie;
        bus.mie_meie     = s.meie;
        bus.irq_timer    = s.tim;
        bus.irq_ext      = s.ext;
    endtask

    // Random activity on request lines while the controller is busy; it must be ignored.
    task automatic garbage();
        bus.instr_valid  = 1'($urandom);
        bus.pc           = $urandom;
        bus.exc_request  = 1'($urandom);
        bus.inst_invalid = 1'($urandom);
        bus.exc_cause    = $urandom;
        bus.exc_ret      = 1'($urandom);
        bus.is_wfi       = 1'($urandom);
        bus.mstatus_mie  = 1'($urandom);
        bus.irq_timer    = 1'($urandom);
        bus.irq_ext      = 1'($urandom);
    endtask

    // Reference decision: kind 0 none, 1 trap, 2 mret, 3 wfi.
    function automatic void model(input stim_t s, output int kind,
                                  output logic [31:0] cause, output logic [31:0] target);
        logic ext_on;
        logic tim_on;
        ext_on = s.ext & s.meie;
        tim_on = s.tim & s.mtie;
        kind   = 0;
        cause  = 32'h0;
        target = 32'h0;
        if (!s.v) begin
            kind = 0;
        end else if (s.mie && (ext_on || tim_on)) begin
            kind  = 1;
            cause = 32'h8000_0000 + (ext_on ? 32'd11 : 32'd7);
        end else if (s.inv) begin
            kind  = 1;
            cause = 32'd2;
        end else if (s.exc_req) begin
            kind  = 1;
            cause = s.exc_cause;
        end else if (s.ret) begin
            kind = 2;
        end else if (s.wfi) begin
            kind = 3;
        end
        if (kind == 1) begin
            target = s.mtvec - (s.mtvec % 32'd4);
            if ((s.mtvec % 32'd4) == 32'd1 && cause >= 32'h8000_0000)
                target = target + 32'd4 * (cause - 32'h8000_0000);
        end
    endfunction

    task automatic apply(input stim_t s, input int wfi_cycles);
        int          kind;
        logic [31:0] cause;
        logic [31:0] target;
        exp_t        e;
        model(s, kind, cause, target);
        drive(s);
        @(negedge clk);
        case (kind)
            1: begin
                chk("detect_kill", 32'(bus.kill), 32'd1);
                chk("detect_stall", 32'(bus.stall), 32'd1);
                e = '{we: 1'b1, mret: 1'b0, redir: 1'b0, epc: s.pc, cause: cause, rpc: 32'h0};
                exp_q.push_back(e);
                e = '{we: 1'b0, mret: 1'b0, redir: 1'b1, epc: 32'h0, cause: 32'h0, rpc: target};
                exp_q.push_back(e);
                @(posedge clk); #1; garbage();
                @(negedge clk);
                chk("save_stall", 32'(bus.stall), 32'd1);
                chk("save_kill", 32'(bus.kill), 32'd0);
                @(posedge clk); #1; garbage();
                @(negedge clk);
                chk("jump_stall", 32'(bus.stall), 32'd0);
                @(posedge clk); #1;
            end
            2: begin
                chk("mret_kill", 32'(bus.kill), 32'd0);
                chk("mret_stall", 32'(bus.stall), 32'd1);
                e = '{we: 1'b0, mret: 1'b1, redir: 1'b1, epc: 32'h0, cause: 32'h0, rpc: s.mepc};
                exp_q.push_back(e);
                @(posedge clk); #1; garbage();
                @(negedge clk);
                chk("ret_stall", 32'(bus.stall), 32'd0);
                @(posedge clk); #1;
            end
            3: begin
                chk("wfi_kill", 32'(bus.kill), 32'd0);
                chk("wfi_stall", 32'(bus.stall), 32'd1);
                for (int i = 0; i < wfi_cycles; i++) begin
                    @(posedge clk); #1; garbage();
                    bus.irq_timer = 1'b0;
                    bus.irq_ext   = 1'b0;
                    @(negedge clk);
                    chk("wfi_wait_stall", 32'(bus.stall), 32'd1);
                    chk("wfi_wait_kill", 32'(bus.kill), 32'd0);
                end
                @(posedge clk); #1;
                drive(idle_stim());
                bus.instr_valid = 1'b1;
                bus.is_wfi      = 1'b1;
                bus.mie_meie    = 1'b1;
                bus.irq_ext     = 1'b1;
                @(negedge clk);
                chk("wfi_wake_stall", 32'(bus.stall), 32'd0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("wfi_masked_stall", 32'(bus.stall), 32'd0);
                chk("wfi_masked_kill", 32'(bus.kill), 32'd0);
                @(posedge clk); #1;
            end
            default: begin
                chk("none_kill", 32'(bus.kill), 32'd0);
                chk("none_stall", 32'(bus.stall), 32'd0);
                @(posedge clk); #1;
            end
        endcase
    endtask

    // Monitor: every cycle with a CSR pulse or redirect consumes exactly one expected event
    always @(negedge clk) begin
        if (!rst && (bus.csr_trap_we || bus.csr_mret || bus.redirect_valid)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got we=%b mret=%b rv=%b rpc=%h expected no event",
                         bus.csr_trap_we, bus.csr_mret, bus.redirect_valid, bus.redirect_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.csr_trap_we !== mon_e.we || bus.csr_mret !== mon_e.mret ||
                    bus.redirect_valid !== mon_e.redir ||
                    (mon_e.we && (bus.epc_out !== mon_e.epc || bus.cause_out !== mon_e.cause)) ||
                    (mon_e.redir && bus.redirect_pc !== mon_e.rpc)) begin
                    n_err++;
                    $display("FAIL event: got we=%b mret=%b rv=%b epc=%h cause=%h rpc=%h expected we=%b mret=%b rv=%b epc=%h cause=%h rpc=%h",
                             bus.csr_trap_we, bus.csr_mret, bus.redirect_valid, bus.epc_out,
                             bus.cause_out, bus.redirect_pc, mon_e.we, mon_e.mret, mon_e.redir,
                             mon_e.epc, mon_e.cause, mon_e.rpc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        drive(idle_stim());
        repeat (2) @(posedge clk);
        #1;
        bus.instr_valid = 1'b1;
        bus.exc_request = 1'b1;
        #1;
        chk("reset_kill", 32'(bus.kill), 32'd0);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_trap_we", 32'(bus.csr_trap_we), 32'd0);
        chk("reset_redirect", 32'(bus.redirect_valid), 32'd0);
        chk("reset_epc", bus.epc_out, 32'h0);
        chk("reset_cause", bus.cause_out, 32'h0);
        drive(idle_stim());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // ECALL, direct mtvec
        s = idle_stim(); s.v = 1'b1; s.pc = 32'h100; s.exc_req = 1'b1; s.exc_cause = 32'd11;
        s.mtvec = 32'h200;
        apply(s, 0);

        // Vectored timer interrupt
        s = idle_stim(); s.v = 1'b1; s.pc = 32'h40; s.mtvec = 32'h201; s.mie = 1'b1;
        s.mtie = 1'b1; s.tim = 1'b1;
        apply(s, 0);

        // External interrupt beats illegal instruction
        s = idle_stim(); s.v = 1'b1; s.pc = 32'h80; s.inv = 1'b1; s.mie = 1'b1; s.meie = 1'b1;
        s.ext = 1'b1; s.mtvec = 32'h300;
        apply(s, 0);

        // MRET
        s = idle_stim(); s.v = 1'b1; s.ret = 1'b1; s.mepc = 32'h104; s.pc = 32'h500;
        apply(s, 0);

        // WFI with global interrupts off, 10 idle cycles
        s = idle_stim(); s.v = 1'b1; s.wfi = 1'b1; s.meie = 1'b1; s.pc = 32'h600;
        apply(s, 10);

        // Reset asserted during TRAP_SAVE
        s = idle_stim(); s.v = 1'b1; s.pc = 32'h700; s.exc_req = 1'b1; s.exc_cause = 32'd11;
        s.mtvec = 32'h200;
        drive(s);
        @(posedge clk); #1;
        chk("pre_reset_trap_we", 32'(bus.csr_trap_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("midtrap_trap_we", 32'(bus.csr_trap_we), 32'd0);
        chk("midtrap_stall", 32'(bus.stall), 32'd0);
        chk("midtrap_epc", bus.epc_out, 32'h0);
        chk("midtrap_cause", bus.cause_out, 32'h0);
        drive(idle_stim());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        s = idle_stim(); s.v = 1'b1; s.pc = 32'h100; s.exc_req = 1'b1; s.exc_cause = 32'd11;
        s.mtvec = 32'h200;
        apply(s, 0);

        // Random mix
        for (int n = 0; n < 250; n++) begin
            s.v         = ($urandom % 8) != 0;
            s.pc        = $urandom & 32'hFFFF_FFFC;
            s.exc_req   = ($urandom % 4) == 0;
            s.inv       = ($urandom % 5) == 0;
            s.exc_cause = (($urandom % 4) == 0) ? $urandom : ($urandom % 16);
            s.ret       = ($urandom % 4) == 0;
            s.wfi       = ($urandom % 3) == 0;
            s.mtvec     = $urandom;
            s.mepc      = $urandom;
            s.mie       = 1'($urandom);
            s.mtie      = 1'($urandom);
            s.meie      = 1'($urandom);
            s.tim       = ($urandom % 4) == 0;
            s.ext       = ($urandom % 4) == 0;
            apply(s, int'($urandom_range(0, 4)));
        end

        drive(idle_stim());
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
